sfp_accum: RTL and testbench
============================

Name: sfp_accum

Overview:
- Special-function/accumulation stage directly downstream of the corelet output FIFO. It consumes psum vectors (col lanes × psum_bw) popped from ofifo and accumulates them across multiple input-channel tiles (passes) in an internal row buffer.
- After the last pass it optionally applies ReLU and drains the finished rows through a valid/ready port to psum memory or sfp_out.

Parameters:
- col, 8, number of psum lanes per vector.
- psum_bw, 16, signed width of each lane.
- ADDR_W, 4, row-buffer address width; DEPTH = 2**ADDR_W rows.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- start  in  1  one-cycle request to begin a job; sampled in IDLE only.
- num_rows  in  ADDR_W+1  rows per pass, legal 1..DEPTH; sampled at start.
- num_passes  in  8  accumulation passes, legal 1..255; sampled at start.
- relu_en  in  1  apply ReLU on drain; sampled at start.
- in_valid  in  1  ofifo has a vector (ofifo_valid).
- in_data  in  col*psum_bw  psum vector; lane k = bits [psum_bw*k +: psum_bw].
- in_ready  out  1  block accepts a vector this cycle (drives ofifo_rd).
- out_valid  out  1  drained row available.
- out_data  out  col*psum_bw  drained row, same lane packing.
- out_addr  out  ADDR_W  row index of out_data.
- out_ready  in  1  downstream accepts the row.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state=IDLE; in_ready, out_valid, busy and done = 0; out_data and out_addr = 0; row_ptr and pass_cnt = 0. Buffer contents need not be cleared. Reset mid-job aborts the job immediately, with no partial drain.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 with num_rows in 1..DEPTH and num_passes≥1: latch the configuration, row_ptr=0, pass_cnt=0, go to ACCUM.
  - Illegal configuration (num_rows==0, num_rows>DEPTH, or num_passes==0): start is ignored, state stays IDLE, busy stays 0.
- ACCUM:
  - in_ready=1 (combinational from state). A beat transfers when in_valid && in_ready.
  - On a beat with pass_cnt==0: buf[row_ptr] = in_data (overwrite).
  - On a beat with pass_cnt>0: buf[row_ptr] = buf[row_ptr] + in_data, per lane, signed, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. There is no carry between lanes.
  - row_ptr increments per beat. At num_rows-1 it wraps to 0 and pass_cnt increments.
  - The beat that completes the last row of the last pass moves the FSM to DRAIN next cycle. in_ready is 0 from that next cycle on.
  - Cycles with in_valid=0 are stalls; no state changes.
- DRAIN:
  - Entry cycle loads the output register with buf[0] (ReLU applied if relu_en: any negative lane becomes 0) and out_addr=0. out_valid=1 from the first DRAIN cycle.
  - On out_valid && out_ready: load the next row in the same cycle-edge, so back-to-back rows transfer at 1 row/cycle.
  - out_ready=0 holds out_data, out_addr and out_valid stable.
  - After the transfer of row num_rows-1: out_valid=0 and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. A new start is accepted in the following IDLE cycle.
- start while busy or in DONE is ignored.
- in_valid outside ACCUM is ignored; nothing is popped.
- Latency: the last accepted input beat is followed by out_valid on the 2nd clock edge after it (one edge into DRAIN, one edge loading row 0).

Test Plan:
- Single pass, no ReLU: num_rows=4, num_passes=1, lane values row r = r−2 in every lane -> out rows addr 0..3 carry −2, −1, 0, 1 in all lanes; done pulses once, one cycle after the addr 3 transfer.
- Three passes with ReLU: num_rows=2. Each pass sends row0 = lane k value (k−4) and row1 = +5. Result: row0 lanes = 3(k−4) with ReLU -> 0,0,0,0,0,3,6,9; row1 = 15 in all lanes.
- Saturation: 2 passes, num_rows=1, lane0 = 30000 each pass -> 32767; lane1 = −30000 each pass -> −32768 (relu_en=0); other lanes = 1+1 = 2.
- Backpressure and stalls: random in_valid gaps during ACCUM and out_ready low for 5 cycles mid-drain -> outputs held stable, no row lost or duplicated, in_ready=0 outside ACCUM.
- Boundary configurations: num_rows=16 (DEPTH) wraps correctly over 2 passes; start with num_rows=0 or num_passes=0 -> busy stays 0; start during ACCUM is ignored.
- Reset mid-job: reset=0 during DRAIN at row 2 -> next cycle IDLE with all outputs 0. A following job with num_rows=1, num_passes=1 then produces correct data with no stale accumulation.

Source files
------------

// File: rtl/sfp_accum.sv
// Accumulates psum vectors over several passes into a row buffer, then drains
// the finished rows with optional ReLU through a valid/ready port.
module sfp_accum #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W:0]        num_rows,
  input  logic [7:0]             num_passes,
  input  logic                   relu_en,
  input  logic                   in_valid,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [col*psum_bw-1:0] out_data,
  output logic [ADDR_W-1:0]      out_addr,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned DW    = col*psum_bw;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W:0]       r_rows;
  logic [7:0]            r_passes;
  logic                  r_relu;
  logic [ADDR_W-1:0]     r_row_ptr;
  logic [7:0]            r_pass_cnt;
  logic [DW-1:0]         r_out_data;
  logic [ADDR_W-1:0]     r_out_addr;
  logic                  r_out_valid;
  logic [DW-1:0]         r_buf [DEPTH];

  logic                  w_cfg_ok;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_row_wrap;
  logic                  w_last_beat;
  logic                  w_drain_last;
  logic                  w_load;
  logic [ADDR_W-1:0]     w_rd_idx;
  logic [DW-1:0]         w_old_row;
  logic [DW-1:0]         w_acc_row;
  logic [DW-1:0]         w_wr_row;
  logic [DW-1:0]         w_rd_row;
  logic [DW-1:0]         w_relu_row;
  logic signed [psum_bw:0] w_sum;

  assign w_cfg_ok     = (num_rows != '0) && (num_rows <= (ADDR_W+1)'(DEPTH)) &&
                        (num_passes != 8'd0);
  assign w_accept     = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_beat       = (r_state == S_ACCUM) && in_valid;
  assign w_row_wrap   = ({1'b0, r_row_ptr} == (r_rows - (ADDR_W+1)'(1)));
  assign w_last_beat  = w_beat && w_row_wrap && (r_pass_cnt == (r_passes - 8'd1));
  assign w_drain_last = r_out_valid && out_ready &&
                        ({1'b0, r_out_addr} == (r_rows - (ADDR_W+1)'(1)));
  // First DRAIN cycle has no row presented yet; afterwards advance on each transfer.
  assign w_load       = (r_state == S_DRAIN) &&
                        (!r_out_valid || (out_ready && !w_drain_last));
  assign w_rd_idx     = r_out_valid ? (r_out_addr + ADDR_W'(1)) : '0;
  assign w_old_row    = r_buf[r_row_ptr];
  assign w_rd_row     = r_buf[w_rd_idx];
  assign w_wr_row     = (r_pass_cnt == 8'd0) ? in_data : w_acc_row;

  assign in_ready  = (r_state == S_ACCUM);
  assign busy      = (r_state == S_ACCUM) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

  // Per-lane signed saturating add, no carry between lanes.
  always_comb begin
    w_acc_row = '0;
    w_sum     = '0;
    for (int k = 0; k < int'(col); k++) begin
      w_sum = (psum_bw+1)'($signed(w_old_row[psum_bw*k +: psum_bw])) +
              (psum_bw+1)'($signed(in_data[psum_bw*k +: psum_bw]));
      if (w_sum[psum_bw] != w_sum[psum_bw-1])
        w_acc_row[psum_bw*k +: psum_bw] = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                          : {1'b0, {(psum_bw-1){1'b1}}};
      else
        w_acc_row[psum_bw*k +: psum_bw] = w_sum[psum_bw-1:0];
    end
  end

  always_comb begin
    w_relu_row = w_rd_row;
    for (int k = 0; k < int'(col); k++) begin
      if (r_relu && w_rd_row[psum_bw*k + psum_bw - 1])
        w_relu_row[psum_bw*k +: psum_bw] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_next = S_ACCUM;
      S_ACCUM: if (w_last_beat)  w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_DONE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rows      <= '0;
      r_passes    <= '0;
      r_relu      <= 1'b0;
      r_row_ptr   <= '0;
      r_pass_cnt  <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rows     <= num_rows;
        r_passes   <= num_passes;
        r_relu     <= relu_en;
        r_row_ptr  <= '0;
        r_pass_cnt <= '0;
      end
      if (w_beat) begin
        if (w_row_wrap) begin
          r_row_ptr  <= '0;
          r_pass_cnt <= r_pass_cnt + 8'd1;
        end else begin
          r_row_ptr  <= r_row_ptr + ADDR_W'(1);
        end
      end
      if (w_load) begin
        r_out_data  <= w_relu_row;
        r_out_addr  <= w_rd_idx;
        r_out_valid <= 1'b1;
      end else if (w_drain_last) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Row buffer has no reset; contents are rewritten by the first pass of every job.
  always_ff @(posedge clk) begin
    if (reset && w_beat) r_buf[r_row_ptr] <= w_wr_row;
  end

endmodule

// File: tb/tb_sfp_accum.sv
// Directed bench for sfp_accum: accumulation, ReLU, saturation, backpressure,
// boundary configurations and mid-job reset.
module tb_sfp_accum;

  localparam int unsigned COL = 8;
  localparam int unsigned PBW = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = COL*PBW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_rows;
  logic [7:0]    num_passes;
  logic          relu_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] cap_data[$];
  int            cap_addr[$];
  int            cap_first_valid;
  int            cap_done_cnt;
  int            cap_done_cycle;
  int            cap_last_xfer;
  int            cap_hold_viol;
  int            cap_inrdy_bad;

  sfp_accum #(.col(COL), .psum_bw(PBW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .num_passes(num_passes), .relu_en(relu_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < int'(COL); k++) r[PBW*k +: PBW] = PBW'(v);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rows, input int passes, input bit relu);
    num_rows   = (AW+1)'(rows);
    num_passes = 8'(passes);
    relu_en    = relu;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int gap);
    in_valid = 1'b0;
    repeat (gap) cycle();
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20 && !in_ready; t++) cycle();
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: in_ready=%b required 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  // Runs the drain phase, recording transferred rows and handshake timing.
  task automatic capture(input int stall_at, input int stall_len);
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    cap_data.delete();
    cap_addr.delete();
    cap_first_valid = -1; cap_done_cnt = 0; cap_done_cycle = -1;
    cap_last_xfer = -1; cap_hold_viol = 0; cap_inrdy_bad = 0;
    prev_hold = 1'b0; prev_data = '0; prev_addr = '0;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      if (in_ready) cap_inrdy_bad++;
      if (prev_hold && (!out_valid || out_data !== prev_data || out_addr !== prev_addr))
        cap_hold_viol++;
      if (out_valid && cap_first_valid < 0) cap_first_valid = c;
      if (done) begin
        cap_done_cnt++;
        if (cap_done_cycle < 0) cap_done_cycle = c;
      end
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_addr.push_back(int'(out_addr));
        cap_last_xfer = c;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
      if (cap_done_cycle >= 0 && c >= cap_done_cycle + 2) break;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cycle();
    n_vec++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_data !== '0 || out_addr !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy/vld/busy/done=%b data=%h addr=%0d required all 0",
               {in_ready, out_valid, busy, done}, out_data, out_addr);
    end
    reset = 1'b1;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single_pass();
    do_start(4, 1, 1'b0);
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_accept: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    for (int r = 0; r < 4; r++) send_beat(splat(r - 2), 0);
    capture(1000, 0);
    n_vec++;
    if (cap_data.size() != 4) begin
      n_err++;
      $display("FAIL single_count: rows=%0d required 4", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 4; i++) begin
      n_vec++;
      if (cap_data[i] !== splat(i - 2) || cap_addr[i] != i) begin
        n_err++;
        $display("FAIL single_row%0d: data=%h addr=%0d required %h addr %0d",
                 i, cap_data[i], cap_addr[i], splat(i - 2), i);
      end
    end
    n_vec++;
    if (cap_first_valid != 1) begin
      n_err++;
      $display("FAIL drain_latency: first out_valid at cycle %0d required 1", cap_first_valid);
    end
    n_vec++;
    if (cap_done_cnt != 1 || cap_done_cycle != cap_last_xfer + 1) begin
      n_err++;
      $display("FAIL single_done: pulses=%0d at %0d required 1 at %0d",
               cap_done_cnt, cap_done_cycle, cap_last_xfer + 1);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_relu_multi();
    logic [DW-1:0] row0;
    logic [DW-1:0] exp0;
    for (int k = 0; k < int'(COL); k++) begin
      row0[PBW*k +: PBW] = PBW'(k - 4);
      exp0[PBW*k +: PBW] = (k > 4) ? PBW'(3 * (k - 4)) : '0;
    end
    do_start(2, 3, 1'b1);
    for (int p = 0; p < 3; p++) begin
      send_beat(row0, 0);
      send_beat(splat(5), 0);
    end
    capture(1000, 0);
    n_vec++;
    if (cap_data.size() != 2) begin
      n_err++;
      $display("FAIL relu_count: rows=%0d required 2", cap_data.size());
    end
    if (cap_data.size() == 2) begin
      n_vec++;
      if (cap_data[0] !== exp0 || cap_addr[0] != 0) begin
        n_err++;
        $display("FAIL relu_row0: data=%h addr=%0d required %h addr 0", cap_data[0], cap_addr[0], exp0);
      end
      n_vec++;
      if (cap_data[1] !== splat(15) || cap_addr[1] != 1) begin
        n_err++;
        $display("FAIL relu_row1: data=%h addr=%0d required %h addr 1", cap_data[1], cap_addr[1], splat(15));
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] v;
    logic [DW-1:0] exp_v;
    v     = splat(1);
    exp_v = splat(2);
    v[PBW*0 +: PBW]     = PBW'(30000);
    v[PBW*1 +: PBW]     = PBW'(-30000);
    exp_v[PBW*0 +: PBW] = 16'h7fff;
    exp_v[PBW*1 +: PBW] = 16'h8000;
    do_start(1, 2, 1'b0);
    send_beat(v, 0);
    send_beat(v, 0);
    capture(1000, 0);
    n_vec++;
    if (cap_data.size() != 1 || cap_data[0] !== exp_v) begin
      n_err++;
      $display("FAIL saturation: rows=%0d data=%h required 1 row %h",
               cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : '0, exp_v);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v;
    logic [DW-1:0] exp_v;
    do_start(3, 2, 1'b0);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < int'(COL); k++) v[PBW*k +: PBW] = PBW'(r * 10 + k - 3 * p);
        send_beat(v, int'($urandom_range(0, 3)));
      end
    capture(2, 5);
    n_vec++;
    if (cap_data.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: rows=%0d required 3", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 3; i++) begin
      for (int k = 0; k < int'(COL); k++) exp_v[PBW*k +: PBW] = PBW'(2 * (i * 10 + k) - 3);
      n_vec++;
      if (cap_data[i] !== exp_v || cap_addr[i] != i) begin
        n_err++;
        $display("FAIL bp_row%0d: data=%h addr=%0d required %h addr %0d",
                 i, cap_data[i], cap_addr[i], exp_v, i);
      end
    end
    n_vec++;
    if (cap_hold_viol != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable stall cycles required 0", cap_hold_viol);
    end
    n_vec++;
    if (cap_inrdy_bad != 0 || cap_done_cnt != 1) begin
      n_err++;
      $display("FAIL bp_ready_done: in_ready-high=%0d done=%0d required 0 and 1",
               cap_inrdy_bad, cap_done_cnt);
    end
  endtask

  task automatic test_boundary();
    int bad_rows[3]   = '{0, 17, 4};
    int bad_passes[3] = '{1, 1, 0};
    logic [DW-1:0] v;
    logic [DW-1:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      do_start(bad_rows[i], bad_passes[i], 1'b0);
      cycle();
      n_vec++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_cfg%0d: busy=%b in_ready=%b required 0 0", i, busy, in_ready);
      end
    end
    do_start(16, 2, 1'b0);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 16; r++) begin
        if (p == 0 && r == 5) begin
          num_rows = 1; num_passes = 1; relu_en = 1'b1; start = 1'b1;
          cycle();
          start = 1'b0;
          n_vec++;
          if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_accum: busy=%b in_ready=%b required 1 1", busy, in_ready);
          end
        end
        for (int k = 0; k < int'(COL); k++) v[PBW*k +: PBW] = PBW'(r * 100 + k + p);
        send_beat(v, 0);
      end
    capture(1000, 0);
    n_vec++;
    if (cap_data.size() != 16 || cap_done_cnt != 1) begin
      n_err++;
      $display("FAIL depth_count: rows=%0d done=%0d required 16 and 1", cap_data.size(), cap_done_cnt);
    end
    for (int i = 0; i < cap_data.size() && i < 16; i++) begin
      for (int k = 0; k < int'(COL); k++) exp_v[PBW*k +: PBW] = PBW'(2 * (i * 100 + k) + 1);
      n_vec++;
      if (cap_data[i] !== exp_v || cap_addr[i] != i) begin
        n_err++;
        $display("FAIL depth_row%0d: data=%h addr=%0d required %h addr %0d",
                 i, cap_data[i], cap_addr[i], exp_v, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    bit            hit;
    do_start(4, 1, 1'b0);
    for (int r = 0; r < 4; r++) send_beat(splat(100 + r), 0);
    hit = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && !hit; t++) begin
      cycle();
      hit = out_valid && (out_addr == 2);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_row2: out_valid=%b addr=%0d required 1 addr 2", out_valid, out_addr);
    end
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    n_vec++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_data !== '0 || out_addr !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: rdy/vld/busy/done=%b data=%h addr=%0d required all 0",
               {in_ready, out_valid, busy, done}, out_data, out_addr);
    end
    for (int k = 0; k < int'(COL); k++) v[PBW*k +: PBW] = PBW'(-7 * k);
    do_start(1, 1, 1'b0);
    send_beat(v, 1);
    capture(1000, 0);
    n_vec++;
    if (cap_data.size() != 1 || cap_data[0] !== v || cap_addr[0] != 0 || cap_done_cnt != 1) begin
      n_err++;
      $display("FAIL post_reset_job: rows=%0d data=%h done=%0d required 1 row %h done 1",
               cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : '0, cap_done_cnt, v);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_rows = '0; num_passes = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_single_pass();
    test_relu_multi();
    test_saturation();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
